// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, opcode constants and FSM state type for the
// instruction fetch unit.
//   ADDR_W  : word-address width of the instruction/data memory
//   WORD_W  : memory word width
//   OP_LDI  : opcode (bits [19:16]) of the only two-word instruction
package fetch_pkg;

  localparam int ADDR_W = 5;
  localparam int WORD_W = 20;

  localparam logic [3:0]        OP_LDI    = 4'b1111;
  localparam logic [ADDR_W-1:0] PC_ONE    = 5'd1;
  localparam logic [ADDR_W-1:0] PC_ZERO   = 5'd0;
  localparam logic [WORD_W-1:0] WORD_ZERO = 20'h00000;

  typedef enum logic [0:0] {
    FETCH     = 1'b0,  // read opcode word at pc
    FETCH_IMM = 1'b1   // read immediate word at pc
  } fetch_state_t;

  // True when the word carries the two-word opcode.
  function automatic logic is_ldi(input logic [WORD_W-1:0] word);
    return (word[WORD_W-1:WORD_W-4] == OP_LDI);
  endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetches one- and two-word instructions from a shared
// single-port memory into a one-entry instruction slot with a valid/ready
// handshake. Branch redirects restart fetch at a new pc.
//
// Optional build macro: FETCH_STORE_PORT_EN adds a store port from the
// memory stage that steals the memory port for one cycle.
//
// Ports:
//   Clock, Reset                 rising-edge clock, async active-high reset
//   mem_addr/mem_q               memory address out, same-cycle read data in
//   mem_data/mem_wr_en           memory write data / enable (tied 0 without
//                                the store port)
//   instr_valid/instr_ready      slot handshake
//   instr_word/instr_imm/instr_pc  slot contents (imm 0 for one-word ops)
//   redirect_valid/redirect_pc   branch redirect
//   st_req/st_addr/st_data/st_ack  store port (FETCH_STORE_PORT_EN only)
module instr_fetch_unit
  import fetch_pkg::*;
(
  input  logic              Clock,
  input  logic              Reset,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_q,
  output logic [WORD_W-1:0] mem_data,
  output logic              mem_wr_en,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [WORD_W-1:0] instr_word,
  output logic [WORD_W-1:0] instr_imm,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
`ifdef FETCH_STORE_PORT_EN
  ,
  input  logic              st_req,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [WORD_W-1:0] st_data,
  output logic              st_ack
`endif
);

  fetch_state_t      state_r, state_nxt_s;
  logic [ADDR_W-1:0] pc_r, pc_nxt_s;
  logic [WORD_W-1:0] pending_r, pending_nxt_s;
  logic              valid_nxt_s;
  logic [WORD_W-1:0] word_nxt_s, imm_nxt_s;
  logic [ADDR_W-1:0] ipc_nxt_s;
  logic              slot_free_s;
  logic              store_s;

  assign slot_free_s = !instr_valid || instr_ready;

`ifdef FETCH_STORE_PORT_EN
  assign store_s = st_req;
  assign st_ack  = st_req;

  // Memory port mux: a store takes the port, otherwise fetch reads at pc.
  always_comb begin
    mem_addr  = pc_r;
    mem_data  = WORD_ZERO;
    mem_wr_en = 1'b0;
    if (store_s) begin
      mem_addr  = st_addr;
      mem_data  = st_data;
      mem_wr_en = 1'b1;
    end else begin
      mem_addr  = pc_r;
    end
  end
`else
  assign store_s   = 1'b0;
  assign mem_addr  = pc_r;
  assign mem_data  = WORD_ZERO;
  assign mem_wr_en = 1'b0;
`endif

  // Next-state logic for the fetch FSM, pc, pending opcode and the slot.
  always_comb begin
    state_nxt_s   = state_r;
    pc_nxt_s      = pc_r;
    pending_nxt_s = pending_r;
    // A handshake empties the slot unless something refills it below.
    valid_nxt_s   = instr_valid && !instr_ready;
    word_nxt_s    = instr_word;
    imm_nxt_s     = instr_imm;
    ipc_nxt_s     = instr_pc;
    if (redirect_valid) begin
      pc_nxt_s      = redirect_pc;
      state_nxt_s   = FETCH;
      valid_nxt_s   = 1'b0;
      pending_nxt_s = WORD_ZERO;
    end else if (store_s) begin
      // Memory port is busy with the store: fetch holds this cycle.
      state_nxt_s = state_r;
    end else begin
      case (state_r)
        FETCH: begin
          if (is_ldi(mem_q)) begin
            // Two-word opcode is parked even if the slot is still full.
            pending_nxt_s = mem_q;
            pc_nxt_s      = pc_r + PC_ONE;
            state_nxt_s   = FETCH_IMM;
          end else if (slot_free_s) begin
            valid_nxt_s = 1'b1;
            word_nxt_s  = mem_q;
            imm_nxt_s   = WORD_ZERO;
            ipc_nxt_s   = pc_r;
            pc_nxt_s    = pc_r + PC_ONE;
          end else begin
            pc_nxt_s = pc_r;
          end
        end
        FETCH_IMM: begin
          if (slot_free_s) begin
            valid_nxt_s = 1'b1;
            word_nxt_s  = pending_r;
            imm_nxt_s   = mem_q;
            // The opcode sat one word before the immediate (wraps at 0).
            ipc_nxt_s   = pc_r - PC_ONE;
            pc_nxt_s    = pc_r + PC_ONE;
            state_nxt_s = FETCH;
          end else begin
            pc_nxt_s = pc_r;
          end
        end
        default: begin
          state_nxt_s = FETCH;
        end
      endcase
    end
  end

  // State and slot registers.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_r     <= FETCH;
      pc_r        <= PC_ZERO;
      pending_r   <= WORD_ZERO;
      instr_valid <= 1'b0;
      instr_word  <= WORD_ZERO;
      instr_imm   <= WORD_ZERO;
      instr_pc    <= PC_ZERO;
    end else begin
      state_r     <= state_nxt_s;
      pc_r        <= pc_nxt_s;
      pending_r   <= pending_nxt_s;
      instr_valid <= valid_nxt_s;
      instr_word  <= word_nxt_s;
      instr_imm   <= imm_nxt_s;
      instr_pc    <= ipc_nxt_s;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed and randomized checks of instr_fetch_unit
// against a memory model and an instruction-stream reference model.
// Store-port steps are built only with FETCH_STORE_PORT_EN.
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [4:0]  mem_addr;
  logic [19:0] mem_q, mem_data;
  logic        mem_wr_en;
  logic        instr_valid, instr_ready;
  logic [19:0] instr_word, instr_imm;
  logic [4:0]  instr_pc;
  logic        redirect_valid;
  logic [4:0]  redirect_pc;
`ifdef FETCH_STORE_PORT_EN
  logic        st_req, st_ack;
  logic [4:0]  st_addr;
  logic [19:0] st_data;
`endif

  logic [19:0] mem [32];
  assign mem_q = mem[mem_addr];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clock = ~Clock;

  instr_fetch_unit dut (
    .Clock(Clock), .Reset(Reset),
    .mem_addr(mem_addr), .mem_q(mem_q), .mem_data(mem_data), .mem_wr_en(mem_wr_en),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_word(instr_word), .instr_imm(instr_imm), .instr_pc(instr_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
`ifdef FETCH_STORE_PORT_EN
    , .st_req(st_req), .st_addr(st_addr), .st_data(st_data), .st_ack(st_ack)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock: memory writes land on the negedge, checks resume 1 after posedge.
  task automatic cyc();
    @(negedge Clock);
    if (mem_wr_en === 1'b1) mem[mem_addr] = mem_data;
    @(posedge Clock);
    #1;
  endtask

  function automatic logic [19:0] rand_one();
    logic [3:0]  op;
    logic [15:0] lo;
    op = 4'($urandom_range(0, 14));
    lo = 16'($urandom);
    return {op, lo};
  endfunction

  function automatic logic [19:0] rand_any();
    logic [15:0] lo;
    lo = 16'($urandom);
    if ($urandom_range(0, 3) == 0) return {4'hF, lo};
    else return rand_one();
  endfunction

  initial begin
    logic [4:0]  exp_pc;
    logic [19:0] e_word, e_imm;
    int          transfers;
    logic        redir;

    Reset = 1'b1; instr_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 5'd0;
`ifdef FETCH_STORE_PORT_EN
    st_req = 1'b0; st_addr = 5'd0; st_data = 20'h0;
`endif
    for (int i = 0; i < 32; i++) mem[i] = rand_one();

    // Two one-word instructions, then back-to-back throughput.
    mem[0] = 20'h10000; mem[1] = 20'h20000;
    cyc();
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_word", instr_word, 20'h0);
    chk("rst_imm", instr_imm, 20'h0);
    chk("rst_pc", instr_pc, 5'd0);
    chk("rst_addr", mem_addr, 5'd0);
    chk("rst_wr_en", mem_wr_en, 1'b0);
    chk("rst_data", mem_data, 20'h0);
    Reset = 1'b0;
    cyc();
    chk("e1_valid", instr_valid, 1'b1);
    chk("e1_word", instr_word, 20'h10000);
    chk("e1_pc", instr_pc, 5'd0);
    chk("e1_imm", instr_imm, 20'h0);
    cyc();
    chk("e2_valid", instr_valid, 1'b1);
    chk("e2_word", instr_word, 20'h20000);
    chk("e2_pc", instr_pc, 5'd1);
    for (int i = 2; i < 6; i++) begin
      cyc();
      chk("b2b_valid", instr_valid, 1'b1);
      chk("b2b_word", instr_word, mem[i]);
      chk("b2b_pc", instr_pc, 5'(i));
    end

    // Two-word instruction at 0, then a stall on the following one.
    Reset = 1'b1;
    mem[0] = 20'hF4000; mem[1] = 20'h00010; mem[2] = 20'h30000; mem[3] = 20'h12345;
    cyc();
    Reset = 1'b0;
    cyc();
    chk("ldi_e1_valid", instr_valid, 1'b0);
    chk("ldi_e1_addr", mem_addr, 5'd1);
    cyc();
    chk("ldi_valid", instr_valid, 1'b1);
    chk("ldi_word", instr_word, 20'hF4000);
    chk("ldi_imm", instr_imm, 20'h00010);
    chk("ldi_pc", instr_pc, 5'd0);
    chk("ldi_next_addr", mem_addr, 5'd2);
    cyc();
    chk("after_ldi_word", instr_word, 20'h30000);
    chk("after_ldi_pc", instr_pc, 5'd2);
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_valid", instr_valid, 1'b1);
      chk("stall_word", instr_word, 20'h30000);
      chk("stall_pc", instr_pc, 5'd2);
      chk("stall_addr", mem_addr, 5'd3);
    end
    instr_ready = 1'b1;
    cyc();
    chk("resume_word", instr_word, 20'h12345);
    chk("resume_pc", instr_pc, 5'd3);

    // Redirect while a two-word opcode is pending and the slot is full.
    Reset = 1'b1; instr_ready = 1'b0;
    mem[0] = 20'h10000; mem[1] = 20'hF0001; mem[2] = 20'h66666;
    mem[7] = 20'h70000; mem[8] = 20'h80000;
    cyc();
    Reset = 1'b0;
    cyc();
    chk("rd_e1_word", instr_word, 20'h10000);
    cyc();
    chk("rd_hold_valid", instr_valid, 1'b1);
    chk("rd_imm_addr", mem_addr, 5'd2);
    redirect_valid = 1'b1; redirect_pc = 5'd7;
    cyc();
    chk("rd_drop_valid", instr_valid, 1'b0);
    chk("rd_addr", mem_addr, 5'd7);
    redirect_valid = 1'b0; instr_ready = 1'b1;
    cyc();
    chk("rd_valid", instr_valid, 1'b1);
    chk("rd_word", instr_word, 20'h70000);
    chk("rd_pc", instr_pc, 5'd7);
    chk("rd_imm", instr_imm, 20'h0);
    cyc();
    chk("rd_next_pc", instr_pc, 5'd8);

    // Two-word instruction at 31 wraps its immediate to address 0.
    mem[31] = 20'hF1234; mem[0] = 20'h00ABC; mem[1] = 20'h40000;
    redirect_valid = 1'b1; redirect_pc = 5'd31;
    cyc();
    chk("wrap_addr31", mem_addr, 5'd31);
    redirect_valid = 1'b0;
    cyc();
    chk("wrap_imm_addr", mem_addr, 5'd0);
    cyc();
    chk("wrap_valid", instr_valid, 1'b1);
    chk("wrap_word", instr_word, 20'hF1234);
    chk("wrap_imm", instr_imm, 20'h00ABC);
    chk("wrap_pc", instr_pc, 5'd31);
    chk("wrap_next_addr", mem_addr, 5'd1);

    // Reset in the middle of a two-word fetch.
    redirect_valid = 1'b1; redirect_pc = 5'd31;
    cyc();
    redirect_valid = 1'b0;
    cyc();
    chk("mid_imm_addr", mem_addr, 5'd0);
    Reset = 1'b1;
    #1;
    chk("arst_valid", instr_valid, 1'b0);
    chk("arst_word", instr_word, 20'h0);
    chk("arst_imm", instr_imm, 20'h0);
    chk("arst_pc", instr_pc, 5'd0);
    chk("arst_addr", mem_addr, 5'd0);
    cyc();
    Reset = 1'b0;
    cyc();
    chk("restart_valid", instr_valid, 1'b1);
    chk("restart_word", instr_word, 20'h00ABC);
    chk("restart_pc", instr_pc, 5'd0);
    chk("restart_imm", instr_imm, 20'h0);

`ifdef FETCH_STORE_PORT_EN
    // Store steals the port for one cycle; fetch holds and resumes.
    instr_ready = 1'b0;
    mem[5] = 20'h0;
    st_req = 1'b1; st_addr = 5'd5; st_data = 20'hABCDE;
    #1;
    chk("st_addr", mem_addr, 5'd5);
    chk("st_wr_en", mem_wr_en, 1'b1);
    chk("st_ack", st_ack, 1'b1);
    chk("st_data", mem_data, 20'hABCDE);
    cyc();
    chk("st_mem5", mem[5], 20'hABCDE);
    chk("st_hold_word", instr_word, 20'h00ABC);
    st_req = 1'b0; instr_ready = 1'b1;
    #1;
    chk("st_pc_kept", mem_addr, 5'd1);
    chk("st_ack_low", st_ack, 1'b0);
    cyc();
    chk("st_resume_word", instr_word, 20'h40000);
    chk("st_resume_pc", instr_pc, 5'd1);
`endif

    // Random program, random ready and redirects vs. instruction-stream model.
    Reset = 1'b1;
    for (int i = 0; i < 32; i++) mem[i] = rand_any();
    cyc();
    Reset = 1'b0;
    exp_pc = 5'd0;
    transfers = 0;
    for (int c = 0; c < 600; c++) begin
      instr_ready    = ($urandom_range(0, 3) != 0);
      redir          = ($urandom_range(0, 19) == 0);
      redirect_valid = redir;
      redirect_pc    = 5'($urandom);
      if (instr_valid === 1'b1 && instr_ready) begin
        e_word = mem[exp_pc];
        if (e_word[19:16] == 4'hF) begin
          e_imm  = mem[5'(exp_pc + 5'd1)];
          chk("rnd_word", instr_word, e_word);
          chk("rnd_imm", instr_imm, e_imm);
          chk("rnd_pc", instr_pc, exp_pc);
          exp_pc = exp_pc + 5'd2;
        end else begin
          chk("rnd_word", instr_word, e_word);
          chk("rnd_imm", instr_imm, 20'h0);
          chk("rnd_pc", instr_pc, exp_pc);
          exp_pc = exp_pc + 5'd1;
        end
        transfers++;
      end
      if (redir) exp_pc = redirect_pc;
      cyc();
    end
    redirect_valid = 1'b0;
    chk("rnd_progress", 32'(transfers >= 150), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The module SHALL use a single clock and an asynchronous, active-high reset, with ports named Clock and Reset.
REQ-002 Clock  input  1  rising-edge clock; all state updates on posedge.
REQ-003 Reset  input  1  asynchronous, active-high.
REQ-004 mem_addr  output  5  word address to the instruction/data memory (combinational read, negedge write).
REQ-005 mem_q  input  20  read data for mem_addr, same cycle.
REQ-006 mem_data  output  20  write data to memory.
REQ-007 mem_wr_en  output  1  memory write enable.
REQ-008 instr_valid  output  1  instruction slot holds a valid instruction.
REQ-009 instr_ready  input  1  decode accepts the slot; transfer occurs when valid && ready at posedge.
REQ-010 instr_word / instr_imm  output  20 each  opcode word, and the immediate word (0 for one-word instructions).
REQ-011 instr_pc  output  5  address of instr_word.
REQ-012 redirect_valid, redirect_pc  input  1, 5  branch redirect request and target.
REQ-013 st_req, st_addr, st_data  input  1, 5, 20  store request from the memory stage.
REQ-014 st_ack  output  1  high in the cycle the store drives the memory port.

Function
REQ-015 Two-word instructions SHALL be those with mem_q[19:16] == OP_LDI (4'b1111); every other opcode is one word.
REQ-016 FSM states SHALL be FETCH (read opcode word at pc) and FETCH_IMM (read immediate at pc).
REQ-017 When not storing, mem_addr SHALL equal pc, mem_wr_en SHALL be 0, and mem_data SHALL be 0.
REQ-018 The slot is free when !instr_valid || instr_ready.
REQ-019 FETCH with a free slot and a one-word opcode SHALL load instr_word=mem_q, instr_imm=0, instr_pc=pc, set instr_valid, and increment pc.
REQ-020 FETCH with an OP_LDI word SHALL capture it into a pending register, increment pc, and move to FETCH_IMM, whether or not the slot is free.
REQ-021 FETCH_IMM with a free slot SHALL publish the pending word with instr_imm=mem_q, increment pc, and return to FETCH; without a free slot it SHALL hold.
REQ-022 When the slot is consumed and no new instruction is loaded, instr_valid SHALL clear; back-to-back one-word fetches SHALL sustain one instruction per cycle.
REQ-023 pc SHALL wrap from 31 to 0; an OP_LDI at address 31 takes its immediate from address 0.
REQ-024 st_req SHALL have priority over fetch: mem_addr=st_addr, mem_data=st_data, mem_wr_en=1, st_ack=1 that cycle, and FSM/pc/slot hold (a slot handshake still clears instr_valid).
REQ-025 redirect_valid at posedge SHALL set pc=redirect_pc, state=FETCH, instr_valid=0, and discard pending, overriding every other update; a coincident store still completes.
REQ-026 Outputs SHALL be registered except mem_addr, mem_data, mem_wr_en, and st_ack.

Reset
REQ-027 Reset SHALL force pc=0, state=FETCH, instr_valid=0, instr_word=instr_imm=0, instr_pc=0, and pending=0.
REQ-028 Reset mid-FETCH_IMM SHALL drop the partial instruction; the first valid instruction after release is from address 0.

Configuration
REQ-029 With FETCH_STORE_PORT_EN defined, the store ports and REQ-024 SHALL be present.
REQ-030 Without FETCH_STORE_PORT_EN, the st_* ports SHALL be absent, st_ack omitted, mem_wr_en tied 0, and mem_data tied 0.

Structure
REQ-031 Package fetch_pkg SHALL hold ADDR_W=5, WORD_W=20, OP_LDI=4'b1111, and the FSM state typedef.
REQ-032 The block SHALL be a single module with no sub-module.

Verification
REQ-033 Mem[0]=0x10000, Mem[1]=0x20000, ready=1 -> instr_valid on edges 1 and 2, instr_pc 0 then 1, instr_imm=0.
REQ-034 Mem[0]=0xF4000, Mem[1]=0x00010 -> a single instruction with word=0xF4000, imm=0x00010, pc=0, valid after edge 2; next fetch at pc=2.
REQ-035 instr_ready=0 for 3 cycles with valid=1 -> outputs stable, pc stable; raising ready resumes with no lost or duplicated instruction.
REQ-036 st_req with st_addr=5, st_data=0xABCDE during fetch -> mem_wr_en=1, st_ack=1, Mem[5]=0xABCDE after negedge, fetch resumes at the unchanged pc.
REQ-037 redirect_pc=7 asserted while in FETCH_IMM -> valid drops next cycle, pending discarded, next instruction has instr_pc=7.
REQ-038 OP_LDI at 31 -> imm read from address 0, pc becomes 1; assert Reset mid-sequence -> all outputs 0 and fetch restarts at 0.
